// File: rtl/uart_configurable.sv
// Full-duplex UART with compile-time frame format and a FWFT RX FIFO.
// Oversamples at 8 ticks per bit; RX entries carry parity and framing flags.
module uart_configurable #(
    parameter int CLK_FREQUENCY = 100000000,
    parameter int BAUD_RATE     = 115200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_pop,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 tx,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy
);

    localparam int DIV_RAW = (CLK_FREQUENCY + 4 * BAUD_RATE) / (8 * BAUD_RATE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW      = $clog2(RX_FIFO_DEPTH);
    localparam int EW      = DATA_BITS + 2;

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic          HAS_PAR   = (PARITY != 0);
    localparam logic          PAR_ODD   = (PARITY == 2);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(RX_FIFO_DEPTH);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

    // ---------------- transmitter ----------------
    tx_state_t             tx_state, tx_state_n;
    logic [DW-1:0]         tx_div;
    logic [2:0]            tx_tcnt;
    logic [2:0]            tx_idx, tx_idx_n;
    logic [DATA_BITS-1:0]  tx_buf;
    logic                  tx_par;
    logic                  tx_n;
    logic                  tx_tick;
    logic                  tx_bit_end;

    assign tx_tick    = (tx_div == DIV_LAST);
    assign tx_bit_end = tx_tick && (tx_tcnt == 3'd7);
    assign tx_busy    = (tx_state != TX_IDLE);

    always_comb begin
        tx_state_n = tx_state;
        unique case (tx_state)
            TX_IDLE:   if (tx_start) tx_state_n = TX_START;
            TX_START:  if (tx_bit_end) tx_state_n = TX_DATA;
            TX_DATA: begin
                if (tx_bit_end && tx_idx == LAST_DATA)
                    tx_state_n = HAS_PAR ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: if (tx_bit_end) tx_state_n = TX_STOP;
            TX_STOP: begin
                if (tx_bit_end && tx_idx == LAST_STOP)
                    tx_state_n = TX_IDLE;
            end
            default:   tx_state_n = TX_IDLE;
        endcase

        tx_idx_n = tx_idx;
        if (tx_state == TX_IDLE)
            tx_idx_n = '0;
        else if (tx_bit_end)
            tx_idx_n = (tx_state_n != tx_state) ? 3'd0 : tx_idx + 3'd1;

        // Line level is registered from the next state so tx never glitches.
        unique case (tx_state_n)
            TX_START:  tx_n = 1'b0;
            TX_DATA:   tx_n = tx_buf[tx_idx_n];
            TX_PARITY: tx_n = tx_par;
            default:   tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_idx   <= '0;
            tx_div   <= '0;
            tx_tcnt  <= '0;
            tx_buf   <= '0;
            tx_par   <= 1'b0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_idx   <= tx_idx_n;
            tx       <= tx_n;
            if (tx_state == TX_IDLE) begin
                tx_div  <= '0;
                tx_tcnt <= '0;
                if (tx_start) begin
                    tx_buf <= tx_data;
                    tx_par <= (^tx_data) ^ PAR_ODD;
                end
            end else begin
                tx_div <= tx_tick ? '0 : tx_div + 1'b1;
                if (tx_tick)
                    tx_tcnt <= tx_tcnt + 3'd1;
            end
        end
    end

    // ---------------- receiver ----------------
    rx_state_t             rx_state, rx_state_n;
    logic [1:0]            rx_sync;
    logic                  rx_s;
    logic [DW-1:0]         rx_div;
    logic                  rx_tick;
    logic [2:0]            rx_tcnt;
    logic [2:0]            rx_idx;
    logic                  rx_samp;
    logic [DATA_BITS-1:0]  rx_shift;
    logic                  rx_perr;
    logic                  rx_ferr;
    logic                  rx_wr;

    assign rx_s    = rx_sync[1];
    assign rx_tick = (rx_div == DIV_LAST);
    // Start bit is checked half a bit in; every later sample is one bit on.
    assign rx_samp = rx_tick &&
                     (rx_tcnt == ((rx_state == RX_START) ? 3'd3 : 3'd7));

    always_comb begin
        rx_state_n = rx_state;
        unique case (rx_state)
            RX_IDLE:   if (!rx_s) rx_state_n = RX_START;
            RX_START:  if (rx_samp) rx_state_n = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (rx_samp && rx_idx == LAST_DATA)
                    rx_state_n = HAS_PAR ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: if (rx_samp) rx_state_n = RX_STOP;
            RX_STOP: begin
                if (rx_samp && rx_idx == LAST_STOP)
                    rx_state_n = (rx_ferr || !rx_s) ? RX_WAIT_HIGH : RX_IDLE;
            end
            RX_WAIT_HIGH: if (rx_s) rx_state_n = RX_IDLE;
            default:   rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_sync  <= 2'b11;
            rx_div   <= '0;
            rx_tcnt  <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_perr  <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_wr    <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], rx};
            rx_div   <= rx_tick ? '0 : rx_div + 1'b1;
            rx_state <= rx_state_n;
            rx_wr    <= 1'b0;
            if (rx_state_n != rx_state)
                rx_tcnt <= '0;
            else if (rx_tick)
                rx_tcnt <= rx_tcnt + 3'd1;
            if (rx_state == RX_START) begin
                rx_perr <= 1'b0;
                rx_ferr <= 1'b0;
                rx_idx  <= '0;
            end
            if (rx_samp && rx_state != RX_START) begin
                rx_idx <= (rx_state_n != rx_state) ? 3'd0 : rx_idx + 3'd1;
                if (rx_state == RX_DATA)
                    rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                if (rx_state == RX_PARITY)
                    rx_perr <= (^rx_shift) ^ rx_s ^ PAR_ODD;
                if (rx_state == RX_STOP) begin
                    if (!rx_s)
                        rx_ferr <= 1'b1;
                    if (rx_idx == LAST_STOP)
                        rx_wr <= 1'b1;
                end
            end
        end
    end

    // ---------------- RX FIFO ----------------
    logic [EW-1:0] mem [RX_FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          full, pop, wr, ovf;
    logic [EW-1:0] head;

    assign full     = (count == FULL_CNT);
    assign rx_valid = (count != '0);
    assign pop      = rx_pop && rx_valid;
    // A pop in the same cycle frees the slot the incoming frame needs.
    assign wr       = rx_wr && (!full || pop);
    assign ovf      = rx_wr && full && !pop;
    assign head     = mem[rptr];

    assign rx_data       = rx_valid ? head[EW-1:2] : '0;
    assign rx_parity_err = rx_valid && head[1];
    assign rx_frame_err  = rx_valid && head[0];

    always_ff @(posedge clk) begin
        if (wr)
            mem[wptr] <= {rx_shift, rx_perr, rx_ferr};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (wr)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            unique case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (ovf)
                rx_overrun <= 1'b1;
            else if (pop)
                rx_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_configurable.sv
// Bench for uart_configurable: 8E1 loopback, 8O2 and 7N1 driven receivers.
// A frame-level model predicts tx waveforms and RX FIFO entries.
module tb_uart_configurable;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic       loop_a;
    logic [2:0] drv;
    logic [2:0] pop_v;
    logic       rx_a;
    logic       tx_a, busy_a, tx_start_a;
    logic [7:0] tx_data_a;
    logic [7:0] rd_a, rd_b;
    logic [6:0] rd_c;
    logic [2:0] rv, pe, fe, ov;
    logic       tx_b, busy_b, tx_c, busy_c;

    assign rx_a = loop_a ? tx_a : drv[0];

    uart_configurable #(
        .CLK_FREQUENCY(16000000), .BAUD_RATE(1000000),
        .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .RX_FIFO_DEPTH(4)
    ) u_a (
        .clk(clk), .reset(rst), .rx(rx_a),
        .rx_data(rd_a), .rx_valid(rv[0]), .rx_pop(pop_v[0]),
        .rx_parity_err(pe[0]), .rx_frame_err(fe[0]), .rx_overrun(ov[0]),
        .tx(tx_a), .tx_start(tx_start_a), .tx_data(tx_data_a), .tx_busy(busy_a)
    );

    uart_configurable #(
        .CLK_FREQUENCY(16000000), .BAUD_RATE(1000000),
        .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .RX_FIFO_DEPTH(4)
    ) u_b (
        .clk(clk), .reset(rst), .rx(drv[1]),
        .rx_data(rd_b), .rx_valid(rv[1]), .rx_pop(pop_v[1]),
        .rx_parity_err(pe[1]), .rx_frame_err(fe[1]), .rx_overrun(ov[1]),
        .tx(tx_b), .tx_start(1'b0), .tx_data(8'h00), .tx_busy(busy_b)
    );

    uart_configurable #(
        .CLK_FREQUENCY(16000000), .BAUD_RATE(1000000),
        .DATA_BITS(7), .PARITY(0), .STOP_BITS(1), .RX_FIFO_DEPTH(4)
    ) u_c (
        .clk(clk), .reset(rst), .rx(drv[2]),
        .rx_data(rd_c), .rx_valid(rv[2]), .rx_pop(pop_v[2]),
        .rx_parity_err(pe[2]), .rx_frame_err(fe[2]), .rx_overrun(ov[2]),
        .tx(tx_c), .tx_start(1'b0), .tx_data(7'h00), .tx_busy(busy_c)
    );

    // ---------------- model ----------------
    logic [9:0] qa[$];
    logic [9:0] qb[$];
    logic [9:0] qc[$];
    logic [2:0] ov_exp;

    logic        mon_on;
    int          mon_k;
    int          mon_len;
    logic [15:0] mon_bits;

    function automatic void chk(input string nm, input logic [31:0] got,
                                input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endfunction

    function automatic void build_frame(input logic [7:0] d, input int nb,
                                        input int par, input int st,
                                        input logic flip_par, input logic low_stop,
                                        output logic [15:0] bits, output int len);
        int ones = 0;
        bits = '1;
        bits[0] = 1'b0;
        len = 1;
        for (int i = 0; i < nb; i++) begin
            bits[len] = d[i];
            ones += int'(d[i]);
            len++;
        end
        if (par != 0) begin
            bits[len] = ((par == 1) ? (ones % 2 == 1) : (ones % 2 == 0)) ^ flip_par;
            len++;
        end
        for (int i = 0; i < st; i++) begin
            bits[len] = !low_stop;
            len++;
        end
    endfunction

    // What a receiver must store for a line frame: {ferr, perr, data}.
    function automatic logic [9:0] frame_entry(input logic [15:0] bits, input int nb,
                                               input int par, input int st);
        logic [7:0] d = 8'h00;
        int   ones = 0;
        logic p_e = 1'b0;
        logic f_e = 1'b0;
        int   pos;
        for (int i = 0; i < nb; i++) begin
            d[i] = bits[1 + i];
            ones += int'(bits[1 + i]);
        end
        pos = 1 + nb;
        if (par != 0) begin
            ones += int'(bits[pos]);
            p_e = (par == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
            pos++;
        end
        for (int i = 0; i < st; i++)
            if (!bits[pos + i]) f_e = 1'b1;
        return {f_e, p_e, d};
    endfunction

    function automatic void model_push(input int w, input logic [9:0] e);
        case (w)
            0: if (qa.size() == 4) ov_exp[0] = 1'b1; else qa.push_back(e);
            1: if (qb.size() == 4) ov_exp[1] = 1'b1; else qb.push_back(e);
            default: if (qc.size() == 4) ov_exp[2] = 1'b1; else qc.push_back(e);
        endcase
    endfunction

    function automatic logic [7:0] rd_of(input int w);
        case (w)
            0: return rd_a;
            1: return rd_b;
            default: return {1'b0, rd_c};
        endcase
    endfunction

    // Cycle-by-cycle tx line and busy check against the model frame.
    always @(negedge clk) begin
        if (mon_on) begin
            if (mon_k < mon_len * 16) begin
                chk("tx_line", 32'(tx_a), 32'(mon_bits[mon_k / 16]));
                chk("tx_busy", 32'(busy_a), 32'd1);
            end else begin
                chk("tx_line_idle", 32'(tx_a), 32'd1);
                chk("tx_busy_idle", 32'(busy_a), 32'd0);
            end
            mon_k++;
        end
    end

    // ---------------- tasks ----------------
    task automatic send_a(input logic [7:0] d);
        int n = 0;
        logic [15:0] bits;
        int len;
        @(negedge clk);
        while (busy_a && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy_a) begin
            total++;
            bad++;
            $display("FAIL send_wait busy=%0d want=0", busy_a);
        end
        tx_start_a = 1'b1;
        tx_data_a  = d;
        @(posedge clk);
        #1;
        tx_start_a = 1'b0;
        build_frame(d, 8, 1, 1, 1'b0, 1'b0, bits, len);
        mon_bits = bits;
        mon_len  = len;
        mon_k    = 0;
        mon_on   = 1'b1;
        model_push(0, frame_entry(bits, 8, 1, 1));
    endtask

    task automatic wait_idle_a();
        int n = 0;
        @(negedge clk);
        while (busy_a && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy_a) begin
            total++;
            bad++;
            $display("FAIL tx_idle_timeout busy=%0d want=0", busy_a);
        end
    endtask

    task automatic drive_line(input int w, input logic [15:0] bits, input int len,
                              input int hold_low);
        @(posedge clk);
        #1;
        for (int i = 0; i < len; i++) begin
            drv[w] = bits[i];
            repeat (16) @(posedge clk);
            #1;
        end
        if (hold_low > 0) begin
            drv[w] = 1'b0;
            repeat (hold_low) @(posedge clk);
            #1;
        end
        drv[w] = 1'b1;
    endtask

    task automatic check_pop(input int w, input string nm);
        logic [9:0] e = 10'h0;
        logic have = 1'b0;
        @(negedge clk);
        chk({nm, "_valid"}, 32'(rv[w]), 32'd1);
        chk({nm, "_ovr"}, 32'(ov[w]), 32'(ov_exp[w]));
        case (w)
            0: if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
            1: if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
            default: if (qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            total++;
            bad++;
            $display("FAIL %s_model_empty got=popped want=entry", nm);
        end
        chk({nm, "_entry"}, 32'({fe[w], pe[w], rd_of(w)}), 32'(e));
        pop_v[w] = 1'b1;
        @(posedge clk);
        #1;
        pop_v[w] = 1'b0;
        ov_exp[w] = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] bits;
        int len;
        int n;
        logic s0, s1, s2, seen;

        rst = 1'b1;
        loop_a = 1'b1;
        drv = 3'b111;
        pop_v = 3'b000;
        tx_start_a = 1'b0;
        tx_data_a = 8'h00;
        mon_on = 1'b0;
        mon_k = 0;
        mon_len = 0;
        mon_bits = '1;
        ov_exp = 3'b000;
        s0 = 1'b1; s1 = 1'b0; s2 = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 32'(tx_a), 32'd1);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_valid", 32'(rv), 32'd0);
        chk("rst_data", 32'(rd_a), 32'd0);
        chk("rst_perr", 32'(pe), 32'd0);
        chk("rst_ferr", 32'(fe), 32'd0);
        chk("rst_ovr", 32'(ov), 32'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // 8E1 loopback of 0xA5 with literal waveform pins
        send_a(8'hA5);
        n = 0;
        do begin
            @(negedge clk);
            if (n == 8)   s0 = tx_a;
            if (n == 24)  s1 = tx_a;
            if (n == 152) s2 = tx_a;
            if (busy_a) n++;
        end while (busy_a && n < 400);
        chk("busy_len", 32'(n), 32'd176);
        chk("start_low", 32'(s0), 32'd0);
        chk("bit0_high", 32'(s1), 32'd1);
        chk("parity_a5", 32'(s2), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("lb_lit", 32'(rd_a), 32'hA5);
        check_pop(0, "lb_a5");

        // overrun: five back-to-back frames, depth four
        for (int i = 1; i <= 5; i++)
            send_a(8'(i));
        wait_idle_a();
        repeat (40) @(posedge clk);
        #1;
        chk("ovr_lit", 32'(ov[0]), 32'd1);
        for (int i = 1; i <= 4; i++)
            check_pop(0, "ovr_pop");
        @(negedge clk);
        chk("ovr_clear", 32'(ov[0]), 32'd0);
        chk("ovr_drained", 32'(rv[0]), 32'd0);

        // 6-clock glitch must not start a frame
        loop_a = 1'b0;
        drv[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        drv[0] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        drv[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rv[0]) seen = 1'b1;
        end
        chk("glitch", 32'(seen), 32'd0);
        loop_a = 1'b1;

        // 8O2 with inverted parity bit
        build_frame(8'h3C, 8, 2, 2, 1'b1, 1'b0, bits, len);
        model_push(1, frame_entry(bits, 8, 2, 2));
        drive_line(1, bits, len, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("b_perr_lit", 32'(pe[1]), 32'd1);
        chk("b_ferr_lit", 32'(fe[1]), 32'd0);
        chk("b_data_lit", 32'(rd_b), 32'h3C);
        check_pop(1, "b_3c");

        // 7N1 framing error, low hold, then a clean frame
        build_frame(8'h55, 7, 0, 1, 1'b0, 1'b1, bits, len);
        model_push(2, frame_entry(bits, 7, 0, 1));
        drive_line(2, bits, len, 40);
        repeat (32) @(posedge clk);
        build_frame(8'h12, 7, 0, 1, 1'b0, 1'b0, bits, len);
        model_push(2, frame_entry(bits, 7, 0, 1));
        drive_line(2, bits, len, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("c_ferr_lit", 32'(fe[2]), 32'd1);
        chk("c_data_lit", 32'(rd_c), 32'h55);
        check_pop(2, "c_55");
        check_pop(2, "c_12");
        @(negedge clk);
        chk("c_no_spurious", 32'(rv[2]), 32'd0);

        // reset during a frame with two entries held
        send_a(8'h11);
        send_a(8'h22);
        wait_idle_a();
        repeat (40) @(posedge clk);
        #1;
        chk("held_two", 32'(rv[0]), 32'd1);
        send_a(8'hF0);
        n = 0;
        while (mon_k < 16 * 4 + 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        mon_on = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_tx", 32'(tx_a), 32'd1);
        chk("arst_busy", 32'(busy_a), 32'd0);
        chk("arst_valid", 32'(rv[0]), 32'd0);
        qa.delete();
        ov_exp = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        send_a(8'h81);
        wait_idle_a();
        repeat (40) @(posedge clk);
        #1;
        chk("post_rst_lit", 32'(rd_a), 32'h81);
        check_pop(0, "post_rst");
        @(negedge clk);
        chk("post_rst_empty", 32'(rv[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
